pump_scheduler: RTL

Sequences the diffuser pump once a spray session is started. It accepts the single-cycle command pulses and menu selections produced by the mode controller: start, stop, manual spray, scent index and timer index. It runs a periodic spray/wait cycle on the selected scent's pump until the session timer expires or a stop is issued. It sits between the mode controller and the pump driver outputs and also reports remaining session minutes to the LCD path.

---
 rtl/pump_sched_pkg.sv | 62 ++++++
 rtl/pump_scheduler_sec_tick.sv | 33 +++
 rtl/pump_scheduler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pump_sched_pkg.sv
// Shared definitions for the diffuser pump scheduler.
// Contents: state encoding, scent indices, session length constants, and
// helpers that map menu selections to minutes and one-hot pump enables.
package pump_sched_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned SCENT_W = 2;
    localparam int unsigned TIMER_W = 2;
    localparam int unsigned PUMP_W  = 3;
    localparam int unsigned MIN_W   = 7;
    localparam int unsigned SUB_W   = 6;

    // State encoding, also driven out for the debug LEDs.
    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_SPRAY  = 2'd1;
    localparam logic [STATE_W-1:0] ST_WAIT   = 2'd2;
    localparam logic [STATE_W-1:0] ST_MANUAL = 2'd3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = ST_IDLE,
        S_SPRAY  = ST_SPRAY,
        S_WAIT   = ST_WAIT,
        S_MANUAL = ST_MANUAL
    } state_t;

    // Scent indices; the index is also the pump_drive bit position.
    localparam logic [SCENT_W-1:0] COTTON = 2'd0;
    localparam logic [SCENT_W-1:0] WOODY  = 2'd1;
    localparam logic [SCENT_W-1:0] CITRUS = 2'd2;

    // Session lengths in minutes.
    localparam logic [MIN_W-1:0] MIN_30  = 7'd30;
    localparam logic [MIN_W-1:0] MIN_60  = 7'd60;
    localparam logic [MIN_W-1:0] MIN_120 = 7'd120;

    // Last value of the seconds-within-minute sub-counter.
    localparam logic [SUB_W-1:0] SUB_LAST = 6'd59;

    // timer_sel to session minutes; the reserved code falls back to 30.
    function automatic logic [MIN_W-1:0] timer_minutes(input logic [TIMER_W-1:0] sel);
        case (sel)
            2'd1:    timer_minutes = MIN_60;
            2'd2:    timer_minutes = MIN_120;
            default: timer_minutes = MIN_30;
        endcase
    endfunction

    // scent_sel to a valid scent index; the reserved code maps to Cotton.
    function automatic logic [SCENT_W-1:0] scent_norm(input logic [SCENT_W-1:0] sel);
        scent_norm = (sel == 2'd3) ? COTTON : sel;
    endfunction

    // Scent index to one-hot pump enable.
    function automatic logic [PUMP_W-1:0] scent_onehot(input logic [SCENT_W-1:0] sel);
        case (scent_norm(sel))
            WOODY:   scent_onehot = 3'b010;
            CITRUS:  scent_onehot = 3'b100;
            default: scent_onehot = 3'b001;
        endcase
    endfunction

endpackage

// File: rtl/pump_scheduler_sec_tick.sv
// sec_tick_gen: 1-second prescaler for the pump scheduler.
// Ports: clk, reset (async active-low), clear (sync zero of the prescaler,
// dominant over enable), enable (count while high), tick (one-cycle pulse
// on the terminal count, only while enabled).
module sec_tick_gen #(
    parameter int unsigned CLK_HZ = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt;

    // Prescaler: wraps at TERM so every second is exactly CLK_HZ cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == TERM) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = enable && !clear && (cnt == TERM);

endmodule

// File: rtl/pump_scheduler.sv
// pump_scheduler: runs the periodic spray/wait cycle on the selected scent's
// pump for a timed session and reports the minutes remaining.
// Ports: clk, reset (async active-low); command pulses pump_on, pump_off,
// manual_on; menu selections scent_sel, timer_sel; registered outputs
// pump_drive (one-hot), busy, remaining_min, done (expiry pulse), state.
// Build option: define PUMP_SCHED_MANUAL_EN to enable the single manual
// spray from IDLE; otherwise manual_on is ignored and MANUAL is unreachable.
module pump_scheduler
    import pump_sched_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 1_000_000,
    parameter int unsigned SPRAY_SEC  = 5,
    parameter int unsigned PERIOD_SEC = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pump_on,
    input  logic               pump_off,
    input  logic               manual_on,
    input  logic [SCENT_W-1:0] scent_sel,
    input  logic [TIMER_W-1:0] timer_sel,
    output logic [PUMP_W-1:0]  pump_drive,
    output logic               busy,
    output logic [MIN_W-1:0]   remaining_min,
    output logic               done,
    output logic [STATE_W-1:0] state
);

`ifdef PUMP_SCHED_MANUAL_EN
    localparam bit MANUAL_EN = 1'b1;
`else
    localparam bit MANUAL_EN = 1'b0;
`endif

    localparam int unsigned PHASE_W = $clog2(PERIOD_SEC + 1);
    localparam logic [PHASE_W-1:0] SPRAY_LAST = PHASE_W'(SPRAY_SEC - 1);
    localparam logic [PHASE_W-1:0] WAIT_LAST  = PHASE_W'(PERIOD_SEC - SPRAY_SEC - 1);

    state_t             state_q;
    logic [PHASE_W-1:0] phase_q;
    logic [SUB_W-1:0]   sub_q;
    logic [SCENT_W-1:0] scent_q;
    logic               tick;
    logic               manual_start_c;
    logic               tick_clear_c;

    assign manual_start_c = MANUAL_EN && manual_on && (state_q == S_IDLE);

    // Any command that starts or ends activity restarts the second boundary.
    assign tick_clear_c = pump_off || pump_on || manual_start_c;

    sec_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_sec_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (tick_clear_c),
        .enable (busy),
        .tick   (tick)
    );

    assign state = state_q;

    // Session FSM with registered outputs. Priority: pump_off, then pump_on
    // (restart), then per-state sequencing; expiry is overridden by restart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            phase_q       <= '0;
            sub_q         <= '0;
            scent_q       <= COTTON;
            pump_drive    <= '0;
            busy          <= 1'b0;
            remaining_min <= '0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            if (pump_off) begin
                state_q       <= S_IDLE;
                phase_q       <= '0;
                sub_q         <= '0;
                pump_drive    <= '0;
                busy          <= 1'b0;
                remaining_min <= '0;
            end else if (pump_on) begin
                state_q       <= S_SPRAY;
                phase_q       <= '0;
                sub_q         <= '0;
                scent_q       <= scent_norm(scent_sel);
                pump_drive    <= scent_onehot(scent_sel);
                busy          <= 1'b1;
                remaining_min <= timer_minutes(timer_sel);
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (manual_start_c) begin
                            state_q    <= S_MANUAL;
                            phase_q    <= '0;
                            pump_drive <= scent_onehot(scent_sel);
                            busy       <= 1'b1;
                        end
                    end

                    S_SPRAY, S_WAIT: begin
                        if (tick) begin
                            // Spray/wait phase sequencing.
                            if (state_q == S_SPRAY) begin
                                if (phase_q == SPRAY_LAST) begin
                                    state_q    <= S_WAIT;
                                    phase_q    <= '0;
                                    pump_drive <= '0;
                                end else begin
                                    phase_q <= phase_q + PHASE_W'(1);
                                end
                            end else begin
                                if (phase_q == WAIT_LAST) begin
                                    // New scent selection is picked up only here.
                                    state_q    <= S_SPRAY;
                                    phase_q    <= '0;
                                    scent_q    <= scent_norm(scent_sel);
                                    pump_drive <= scent_onehot(scent_sel);
                                end else begin
                                    phase_q <= phase_q + PHASE_W'(1);
                                end
                            end

                            // Session clock; expiry overrides the phase update above.
                            if (sub_q == SUB_LAST) begin
                                sub_q <= '0;
                                if (remaining_min <= MIN_W'(1)) begin
                                    state_q       <= S_IDLE;
                                    phase_q       <= '0;
                                    pump_drive    <= '0;
                                    busy          <= 1'b0;
                                    remaining_min <= '0;
                                    done          <= 1'b1;
                                end else begin
                                    remaining_min <= remaining_min - MIN_W'(1);
                                end
                            end else begin
                                sub_q <= sub_q + SUB_W'(1);
                            end
                        end
                    end

                    S_MANUAL: begin
                        if (tick) begin
                            if (phase_q == SPRAY_LAST) begin
                                state_q    <= S_IDLE;
                                phase_q    <= '0;
                                pump_drive <= '0;
                                busy       <= 1'b0;
                            end else begin
                                phase_q <= phase_q + PHASE_W'(1);
                            end
                        end
                    end

                    default: begin
                        state_q    <= S_IDLE;
                        pump_drive <= '0;
                        busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
